// File: rtl/hram_txn_arbiter.sv
// hram_txn_arbiter: round-robin arbiter granting one of three requesters access to the HyperRAM transaction sequencer
// Ports: clk; rst (async, active-low); req_valid/req_kind/req_addr in, req_ready out (per requester);
//        rsp_done/rsp_err one-cycle completion/timeout pulses to the owner;
//        seq_start/seq_kind/seq_addr/seq_abort to the sequencer, seq_done from it;
//        busy (not IDLE) and grant_id (owner, 3 when idle).
module hram_txn_arbiter #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TRWR_CYC    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [5:0]  req_kind,
  input  logic [95:0] req_addr,
  output logic [2:0]  req_ready,
  output logic [2:0]  rsp_done,
  output logic [2:0]  rsp_err,
  output logic        seq_start,
  output logic [1:0]  seq_kind,
  output logic [31:0] seq_addr,
  output logic        seq_abort,
  input  logic        seq_done,
  output logic        busy,
  output logic [1:0]  grant_id
);
  typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, WAIT, RECOVER} state_t;
  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d, win_q, win_d, c1, c2, win;
  logic [1:0]  kind_q, kind_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  rc_q, rc_d;
  logic [2:0]  done_q, done_d, err_q, err_d, own_oh;
  logic        abort_q, abort_d, arm_q, expire;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (arm_q && |req_valid) ? GRANT : IDLE;
      GRANT:   state_d = req_valid[win_q] ? LAUNCH : IDLE;
      LAUNCH:  state_d = WAIT;
      WAIT:    state_d = (seq_done || expire) ? RECOVER : WAIT;
      RECOVER: state_d = (rc_q == 8'(TRWR_CYC - 1)) ? IDLE : RECOVER;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready = (state_q == GRANT) ? own_oh : 3'b000;
    seq_start = state_q == LAUNCH;
    busy      = state_q != IDLE;
    grant_id  = busy ? win_q : 2'd3;
    rsp_done  = done_q;
    rsp_err   = err_q;
    seq_abort = abort_q;
    seq_kind  = kind_q;
    seq_addr  = addr_q;
  end
  // Round-robin search order is ptr, ptr+1, ptr+2 (mod 3); c2 is the fallback when any bit is set.
  always_comb begin
    own_oh  = 3'b001 << win_q;
    c1      = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    c2      = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;
    win     = req_valid[ptr_q] ? ptr_q : req_valid[c1] ? c1 : c2;
    win_d   = (state_q == IDLE) ? win : win_q;
    ptr_d   = (state_q == GRANT && req_valid[win_q]) ? ((win_q == 2'd2) ? 2'd0 : win_q + 2'd1) : ptr_q;
    kind_d  = (state_q == GRANT) ? req_kind[{win_q, 1'b0} +: 2] : kind_q;
    addr_d  = (state_q == GRANT) ? req_addr[{win_q, 5'b0} +: 32] : addr_q;
    cnt_d   = (state_q == LAUNCH) ? 16'd0 : (state_q == WAIT && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    expire  = state_q == WAIT && cnt_q == 16'(TIMEOUT_CYC - 1);
    rc_d    = (state_q == RECOVER) ? rc_q + 8'd1 : 8'd0;
    // A completion on the expiry cycle wins over the abort.
    done_d  = (state_q == WAIT && seq_done) ? own_oh : 3'b000;
    abort_d = expire && !seq_done;
    err_d   = abort_d ? own_oh : 3'b000;
  end
  // arm_q holds off arbitration for one edge after reset release.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      kind_q  <= 2'd0;
      addr_q  <= 32'd0;
      cnt_q   <= 16'd0;
      rc_q    <= 8'd0;
      done_q  <= 3'b000;
      err_q   <= 3'b000;
      abort_q <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      arm_q   <= 1'b1;
    end
endmodule

// File: tb/tb_hram_txn_arbiter.sv
// tb_hram_txn_arbiter: directed self-checking bench for hram_txn_arbiter
module tb_hram_txn_arbiter;
  logic        clk, rst, seq_done;
  logic [2:0]  req_valid, req_ready, rsp_done, rsp_err;
  logic [5:0]  req_kind;
  logic [95:0] req_addr;
  logic        seq_start, seq_abort, busy;
  logic [1:0]  seq_kind, grant_id;
  logic [31:0] seq_addr;
  int n_cmp = 0, n_err = 0;
  hram_txn_arbiter #(.TIMEOUT_CYC(16), .TRWR_CYC(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_kind(req_kind), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_done(rsp_done), .rsp_err(rsp_err), .seq_start(seq_start),
    .seq_kind(seq_kind), .seq_addr(seq_addr), .seq_abort(seq_abort), .seq_done(seq_done),
    .busy(busy), .grant_id(grant_id)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot", {31'b0, $onehot0(req_ready) && $onehot0(rsp_done) && $onehot0(rsp_err)}, 32'd1);
  endtask
  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wait_ready(input logic [2:0] exp, input string tag);
    int k;
    k = 0;
    do begin tick(); k++; end while (req_ready == 3'b000 && k < 40);
    chk(tag, {29'b0, req_ready}, {29'b0, exp});
  endtask
  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    do begin tick(); k++; end while (busy && k < 40);
    chk(tag, {31'b0, busy}, 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [2:0] e;
    rst = 0; seq_done = 0; req_valid = 0; req_kind = 0; req_addr = 0;
    tickn(2);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_gid", {30'b0, grant_id}, 3);
    chk("rst_kind", {30'b0, seq_kind}, 0);
    chk("rst_addr", seq_addr, 0);
    chk("rst_pulses", {23'b0, req_ready, rsp_done, rsp_err, seq_start, seq_abort}, 0);
    // round-robin with all three continuously valid
    req_kind = {2'd2, 2'd1, 2'd0};
    req_addr = {32'h1002, 32'h1001, 32'h1000};
    req_valid = 3'b111; rst = 1;
    tick();
    chk("arm_delay", {31'b0, busy}, 0);
    for (int t = 0; t < 6; t++) begin
      int g;
      g = t % 3;
      e = 3'(1 << g);
      wait_ready(e, "rr_grant");
      chk("rr_gid", {30'b0, grant_id}, g);
      tick();
      if (t == 5) req_valid = 3'b000;
      chk("rr_start", {31'b0, seq_start}, 1);
      chk("rr_addr", seq_addr, 32'h1000 + g);
      chk("rr_kind", {30'b0, seq_kind}, g);
      tick(); seq_done = 1;
      tick(); seq_done = 0;
      chk("rr_done", {29'b0, rsp_done}, {29'b0, e});
    end
    wait_idle("rr_idle");
    // single RDMEM from req0 with exact latencies
    req_kind = {2'd0, 2'd0, 2'd2}; req_addr = {32'h0, 32'h0, 32'h100}; req_valid = 3'b001;
    tick();
    chk("t1_ready", {29'b0, req_ready}, 3'b001);
    chk("t1_gid", {30'b0, grant_id}, 0);
    chk("t1_busy", {31'b0, busy}, 1);
    tick(); req_valid = 3'b000;
    chk("t1_start", {31'b0, seq_start}, 1);
    chk("t1_kind", {30'b0, seq_kind}, 2);
    chk("t1_addr", seq_addr, 32'h100);
    chk("t1_ready_off", {29'b0, req_ready}, 0);
    tickn(5);
    chk("t1_start_off", {31'b0, seq_start}, 0);
    chk("t1_no_early_done", {29'b0, rsp_done}, 0);
    seq_done = 1;
    tick(); seq_done = 0;
    chk("t1_done", {29'b0, rsp_done}, 3'b001);
    chk("t1_abort", {31'b0, seq_abort}, 0);
    tickn(3);
    chk("t1_recover_busy", {31'b0, busy}, 1);
    tick();
    chk("t1_idle", {31'b0, busy}, 0);
    chk("t1_gid_idle", {30'b0, grant_id}, 3);
    // stray seq_done in IDLE
    seq_done = 1;
    tick(); seq_done = 0;
    chk("stray_done", {29'b0, rsp_done}, 0);
    chk("stray_busy", {31'b0, busy}, 0);
    // req1 drops valid in its GRANT cycle
    req_kind = {2'd3, 2'd1, 2'd3}; req_addr = {32'h333, 32'h222, 32'h444}; req_valid = 3'b010;
    tick();
    chk("drop_ready", {29'b0, req_ready}, 3'b010);
    req_valid = 3'b000;
    tick();
    chk("drop_start", {31'b0, seq_start}, 0);
    chk("drop_busy", {31'b0, busy}, 0);
    chk("drop_gid", {30'b0, grant_id}, 3);
    req_valid = 3'b111;
    tick();
    chk("drop_ptr_kept", {29'b0, req_ready}, 3'b010);
    tick(); req_valid = 3'b000;
    chk("to_start", {31'b0, seq_start}, 1);
    chk("to_kind", {30'b0, seq_kind}, 1);
    chk("to_addr", seq_addr, 32'h222);
    // sequencer never answers: abort 16 cycles after WAIT entry
    tickn(16);
    chk("to_abort_early", {31'b0, seq_abort}, 0);
    chk("to_err_early", {29'b0, rsp_err}, 0);
    tick();
    chk("to_abort", {31'b0, seq_abort}, 1);
    chk("to_err", {29'b0, rsp_err}, 3'b010);
    chk("to_no_done", {29'b0, rsp_done}, 0);
    tick();
    chk("to_abort_pulse", {31'b0, seq_abort}, 0);
    wait_idle("to_idle");
    // next request served; seq_done lands on the expiry cycle
    req_valid = 3'b001;
    tick();
    chk("ex_ready", {29'b0, req_ready}, 3'b001);
    tick(); req_valid = 3'b000;
    chk("ex_addr", seq_addr, 32'h444);
    tickn(16);
    seq_done = 1;
    tick(); seq_done = 0;
    chk("ex_done", {29'b0, rsp_done}, 3'b001);
    chk("ex_abort", {31'b0, seq_abort}, 0);
    chk("ex_err", {29'b0, rsp_err}, 0);
    wait_idle("ex_idle");
    // reset in the middle of WAIT
    req_valid = 3'b100;
    tick();
    chk("mr_ready", {29'b0, req_ready}, 3'b100);
    tick(); req_valid = 3'b000;
    chk("mr_start", {31'b0, seq_start}, 1);
    tickn(4);
    #2 rst = 0;
    #1;
    chk("mr_busy", {31'b0, busy}, 0);
    chk("mr_gid", {30'b0, grant_id}, 3);
    chk("mr_kind", {30'b0, seq_kind}, 0);
    chk("mr_addr", seq_addr, 0);
    tickn(2);
    chk("mr_pulses", {23'b0, req_ready, rsp_done, rsp_err, seq_start, seq_abort}, 0);
    req_valid = 3'b111; rst = 1;
    tick();
    chk("mr_arm", {31'b0, busy}, 0);
    tick();
    chk("mr_grant", {29'b0, req_ready}, 3'b001);
    chk("mr_grant_gid", {30'b0, grant_id}, 0);
    tick(); req_valid = 3'b000;
    chk("mr_relaunch", {31'b0, seq_start}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
